accel_stall_ctrl: RTL and testbench

ACCEL_STALL_CTRL -- requirements
Module: accel_stall_ctrl

---
 rtl/accel_pkg.sv | 16 +
 rtl/accel_timeout_cnt.sv | 36 +++
 rtl/accel_stall_ctrl.sv | 118 +++++++++++
 tb/tb_accel_stall_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator launch/stall controller:
// FSM encoding, channel identifiers and the default channel count.
package accel_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_RESUME = 2'd2
   } state_t;

   localparam int CH_HASH    = 0;
   localparam int CH_ENC     = 1;
   localparam int CH_DEC     = 2;
   localparam int NUM_CH_DEF = 3;

endpackage

// File: rtl/accel_timeout_cnt.sv
// Watchdog counter for an outstanding accelerator launch. tc flags the last
// allowed cycle; with TIMEOUT = 0 no counter is built and tc never fires.
module accel_timeout_cnt #(
   parameter  int TIMEOUT = 4096,
   localparam int CNT_W   = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   generate
      if (TIMEOUT == 0) begin : g_none
         logic unused_ok;
         assign unused_ok = &{1'b0, clk, rst_n, clr, en};
         assign tc        = 1'b0;
      end else begin : g_cnt
         localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);
         logic [CNT_W-1:0] cnt;

         // NOTE: state registers use non-blocking assignments so every flop
         // samples pre-edge values regardless of process evaluation order.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)   cnt <= '0;
            else if (clr) cnt <= '0;
            else if (en)  cnt <= cnt + CNT_W'(1);
         end

         // Only meaningful while counting, so idle cycles never report expiry.
         assign tc = en & (cnt == TC_VAL);
      end
   endgenerate

endmodule

// File: rtl/accel_stall_ctrl.sv
// Launches one accelerator channel at a time, freezes the pipeline while it
// runs, and releases every pipeline register for one RESUME cycle afterwards.
module accel_stall_ctrl
   import accel_pkg::*;
#(
   parameter  int NUM_CH  = NUM_CH_DEF,
   parameter  int IDX_W   = 11,
   parameter  int TIMEOUT = 4096,
   localparam int CH_W    = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              launch_vld,
   input  logic [CH_W-1:0]   launch_ch,
   input  logic [IDX_W-1:0]  launch_idx,
   input  logic [NUM_CH-1:0] ch_done,
   input  logic              imem_stall,
   input  logic              dmem_stall,
   input  logic              halt,
   input  logic              err_clr,
   output logic [NUM_CH-1:0] ch_int,
   output logic [IDX_W-1:0]  ch_index,
   output logic              fetch_hold,
   output logic              if_id_wren,
   output logic              id_ex_wren,
   output logic              ex_mem_wren,
   output logic              mem_wb_wren,
   output logic              busy,
   output logic              err_timeout,
   output logic              err_badch,
   output logic [CH_W-1:0]   err_ch
);

   localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(NUM_CH);

   state_t            state, state_nxt;
   logic [CH_W-1:0]   ch_q;
   logic [NUM_CH-1:0] ch_sel;
   logic              act, rs;
   logic              ch_ok, accept, badch;
   logic              done_hit, tc, tmo;

   assign ch_ok  = {1'b0, launch_ch} < CH_LIM;
   assign accept = (state == ST_IDLE) & launch_vld & ch_ok;
   assign badch  = (state == ST_IDLE) & launch_vld & ~ch_ok;

   // Masking with the one-hot select ignores completions from other channels.
   assign ch_sel   = NUM_CH'(1) << ch_q;
   assign done_hit = act & |(ch_done & ch_sel);
   assign tmo      = tc & ~done_hit;

   accel_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (accept),
      .en    (act),
      .tc    (tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // NOTE: each combinational block assigns defaults first so no path leaves
   // an output unassigned and infers a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:   if (accept)           state_nxt = ST_ACTIVE;
         ST_ACTIVE: if (done_hit || tmo)  state_nxt = ST_RESUME;
         ST_RESUME:                       state_nxt = ST_IDLE;
         default:                         state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      act         = (state == ST_ACTIVE);
      rs          = (state == ST_RESUME);
      ch_int      = act ? ch_sel : '0;
      busy        = act | rs;
      if_id_wren  = (~imem_stall & ~dmem_stall & ~halt & ~act) | rs;
      id_ex_wren  = (~dmem_stall & ~halt & ~act) | rs;
      ex_mem_wren = (~dmem_stall & ~halt & ~act) | rs;
      mem_wb_wren = (~halt & ~act) | rs;
      fetch_hold  = dmem_stall | act;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_q     <= '0;
         ch_index <= '0;
      end else if (accept) begin
         ch_q     <= launch_ch;
         ch_index <= launch_idx;
      end
   end

   // Sticky flags: a new error in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_timeout <= 1'b0;
         err_badch   <= 1'b0;
         err_ch      <= '0;
      end else begin
         if (tmo)          err_timeout <= 1'b1;
         else if (err_clr) err_timeout <= 1'b0;

         if (badch)        err_badch <= 1'b1;
         else if (err_clr) err_badch <= 1'b0;

         if (tmo)          err_ch <= ch_q;
      end
   end

endmodule

// File: tb/tb_accel_stall_ctrl.sv
// Directed bench for accel_stall_ctrl (NUM_CH=3, TIMEOUT=8): launches are
// queued on a scoreboard and checked when the channel request appears.
module tb_accel_stall_ctrl;

   localparam int NUM_CH  = 3;
   localparam int IDX_W   = 11;
   localparam int TIMEOUT = 8;
   localparam int CH_W    = 2;

   logic              clk, rst_n;
   logic              launch_vld;
   logic [CH_W-1:0]   launch_ch;
   logic [IDX_W-1:0]  launch_idx;
   logic [NUM_CH-1:0] ch_done;
   logic              imem_stall, dmem_stall, halt, err_clr;
   logic [NUM_CH-1:0] ch_int;
   logic [IDX_W-1:0]  ch_index;
   logic              fetch_hold, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren;
   logic              busy, err_timeout, err_badch;
   logic [CH_W-1:0]   err_ch;

   typedef struct {
      logic [NUM_CH-1:0] ch_int;
      logic [IDX_W-1:0]  idx;
   } exp_t;

   exp_t sb_q[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   accel_stall_ctrl #(
      .NUM_CH  (NUM_CH),
      .IDX_W   (IDX_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .launch_vld  (launch_vld),
      .launch_ch   (launch_ch),
      .launch_idx  (launch_idx),
      .ch_done     (ch_done),
      .imem_stall  (imem_stall),
      .dmem_stall  (dmem_stall),
      .halt        (halt),
      .err_clr     (err_clr),
      .ch_int      (ch_int),
      .ch_index    (ch_index),
      .fetch_hold  (fetch_hold),
      .if_id_wren  (if_id_wren),
      .id_ex_wren  (id_ex_wren),
      .ex_mem_wren (ex_mem_wren),
      .mem_wb_wren (mem_wb_wren),
      .busy        (busy),
      .err_timeout (err_timeout),
      .err_badch   (err_badch),
      .err_ch      (err_ch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_enables(input string tag, input logic [3:0] exp);
      check(tag, {if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren}, exp);
   endtask

   task automatic drive_launch(input logic [CH_W-1:0] ch, input logic [IDX_W-1:0] idx);
      exp_t e;
      launch_vld = 1'b1;
      launch_ch  = ch;
      launch_idx = idx;
      if (ch < CH_W'(NUM_CH)) begin
         e.ch_int = NUM_CH'(1) << ch;
         e.idx    = idx;
         sb_q.push_back(e);
      end
   endtask

   task automatic sb_check(input string tag);
      exp_t e;
      check({tag, "_sb_pending"}, sb_q.size(), 1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check({tag, "_ch_int"}, ch_int, e.ch_int);
         check({tag, "_ch_index"}, ch_index, e.idx);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b0; launch_vld = 1'b0; launch_ch = '0; launch_idx = '0;
      ch_done = '0; imem_stall = 1'b0; dmem_stall = 1'b0; halt = 1'b0; err_clr = 1'b0;

      // Reset state
      #12;
      check("rst_ch_int", ch_int, 0);
      check("rst_ch_index", ch_index, 0);
      check("rst_busy", busy, 0);
      check("rst_err_timeout", err_timeout, 0);
      check("rst_err_badch", err_badch, 0);
      check("rst_err_ch", err_ch, 0);
      tick();
      rst_n = 1'b1;
      tick();
      check_enables("post_rst_enables", 4'b1111);
      check("post_rst_fetch_hold", fetch_hold, 0);

      // Launch ch=1 idx=0x155, done raised in the fifth active cycle
      drive_launch(2'd1, 11'h155);
      tick();
      launch_vld = 1'b0;
      sb_check("l1");
      check("l1_busy", busy, 1);
      check_enables("l1_active_enables", 4'b0000);
      check("l1_fetch_hold", fetch_hold, 1);
      for (int c = 2; c <= 5; c++) begin
         if (c == 3) begin
            launch_vld = 1'b1; launch_ch = 2'd0; launch_idx = 11'h7ff;
         end else begin
            launch_vld = 1'b0;
         end
         tick();
         check($sformatf("l1_ch_int_c%0d", c), ch_int, 3'b010);
      end
      launch_vld = 1'b0;
      check("l1_ignored_launch_idx", ch_index, 11'h155);
      check("l1_sb_empty", sb_q.size(), 0);
      ch_done = 3'b010;
      tick();
      ch_done = '0;
      dmem_stall = 1'b1; halt = 1'b1;
      #1;
      check("l1_resume_ch_int", ch_int, 0);
      check("l1_resume_busy", busy, 1);
      check_enables("l1_resume_enables", 4'b1111);
      halt = 1'b0;
      tick();
      check("l1_idle_busy", busy, 0);
      check_enables("idle_dmem_stall_enables", 4'b0001);
      check("idle_dmem_stall_fetch_hold", fetch_hold, 1);
      check("l1_index_held", ch_index, 11'h155);
      dmem_stall = 1'b0;

      // Launch ch=2 with no done: timeout after exactly TIMEOUT active cycles
      drive_launch(2'd2, 11'h2aa);
      tick();
      launch_vld = 1'b0;
      sb_check("l2");
      n = 0;
      while (ch_int === 3'b100 && n < 20) begin
         n++;
         tick();
      end
      check("l2_active_cycles", n, TIMEOUT);
      check("l2_err_timeout", err_timeout, 1);
      check("l2_err_ch", err_ch, 2);
      check("l2_resume_busy", busy, 1);
      check_enables("l2_resume_enables", 4'b1111);
      tick();
      check("l2_idle_busy", busy, 0);
      check("l2_err_timeout_sticky", err_timeout, 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("l2_err_timeout_cleared", err_timeout, 0);

      // Illegal channel, then set-over-clear, then clear
      drive_launch(2'd3, 11'h011);
      tick();
      launch_vld = 1'b0;
      check("bad_err_badch", err_badch, 1);
      check("bad_ch_int", ch_int, 0);
      check("bad_busy", busy, 0);
      drive_launch(2'd3, 11'h022);
      err_clr = 1'b1;
      tick();
      launch_vld = 1'b0;
      err_clr = 1'b0;
      check("bad_set_wins", err_badch, 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("bad_cleared", err_badch, 0);
      check("bad_sb_empty", sb_q.size(), 0);

      // ch=0 with foreign done bits; own done on the last allowed cycle
      drive_launch(2'd0, 11'h0a5);
      tick();
      launch_vld = 1'b0;
      sb_check("l3");
      ch_done = 3'b110;
      for (int c = 1; c < TIMEOUT; c++) begin
         tick();
         check($sformatf("l3_ch_int_c%0d", c + 1), ch_int, 3'b001);
      end
      ch_done = 3'b001;
      tick();
      ch_done = '0;
      check("l3_resume_busy", busy, 1);
      check("l3_resume_ch_int", ch_int, 0);
      check("l3_no_timeout", err_timeout, 0);
      tick();
      check("l3_idle_busy", busy, 0);
      check("l3_idle_no_timeout", err_timeout, 0);

      // Reset two cycles into ACTIVE
      drive_launch(2'd1, 11'h0f0);
      tick();
      launch_vld = 1'b0;
      sb_check("l4");
      tick();
      check("l4_ch_int_c2", ch_int, 3'b010);
      rst_n = 1'b0;
      #1;
      check("l4_rst_ch_int", ch_int, 0);
      check("l4_rst_busy", busy, 0);
      check("l4_rst_ch_index", ch_index, 0);
      tick();
      rst_n = 1'b1;
      tick();
      check("l4_post_rst_busy", busy, 0);
      check_enables("l4_post_rst_enables", 4'b1111);
      tick();
      check("l4_no_resume_busy", busy, 0);
      check("l4_no_resume_ch_int", ch_int, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
